// File: rtl/pipe_ctrl_unit_if.sv
// Control-unit bus for pipe_ctrl_unit: ID-stage inputs from the fetch/hazard
// side, per-stage control taps back to the datapath.
// master = datapath/hazard side, slave = pipe_ctrl_unit.
interface pipe_ctrl_unit_if #(
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic [6:0]       opcode;
    logic             halt_cond;
    logic             stall;
    logic             flush;

    logic             ex_valid;
    logic             ex_alu_src;
    logic             ex_branch;
    logic             ex_is_jal;
    logic             ex_is_jalr;
    logic             mem_read;
    logic             mem_write;
    logic             wb_write_enable;
    logic             wb_mem_to_reg;
    logic             wb_pc_to_reg;
    logic             illegal_inst;
    logic             is_halted;
    logic [CNT_W-1:0] retire_count;

    modport master (
        output in_valid, opcode, halt_cond, stall, flush,
        input  ex_valid, ex_alu_src, ex_branch, ex_is_jal, ex_is_jalr,
               mem_read, mem_write, wb_write_enable, wb_mem_to_reg,
               wb_pc_to_reg, illegal_inst, is_halted, retire_count
    );

    modport slave (
        input  in_valid, opcode, halt_cond, stall, flush,
        output ex_valid, ex_alu_src, ex_branch, ex_is_jal, ex_is_jalr,
               mem_read, mem_write, wb_write_enable, wb_mem_to_reg,
               wb_pc_to_reg, illegal_inst, is_halted, retire_count
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined RV32I control unit: decodes the opcode in ID and carries the
// control bundle through ID/EX, MEM_STAGES EX/MEM stages and MEM/WB.
// Handles stall/flush bubbles, illegal opcodes and ECALL halt at writeback.
// Optional feature macro: RETIRE_COUNT_EN (retired-instruction counter).
module pipe_ctrl_unit #(
    parameter int MEM_STAGES = 1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    pipe_ctrl_unit_if.slave   bus
);
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

    // Full bundle held in ID/EX.
    typedef struct packed {
        logic valid;
        logic alu_src;
        logic branch;
        logic is_jal;
        logic is_jalr;
        logic mem_read;
        logic mem_write;
        logic write_enable;
        logic mem_to_reg;
        logic pc_to_reg;
        logic halt;
    } ex_ctrl_t;

    // EX-only fields dropped after EX.
    typedef struct packed {
        logic valid;
        logic mem_read;
        logic mem_write;
        logic write_enable;
        logic mem_to_reg;
        logic pc_to_reg;
        logic halt;
    } mem_ctrl_t;

    // Memory-access fields dropped after the last MEM stage.
    typedef struct packed {
        logic valid;
        logic write_enable;
        logic mem_to_reg;
        logic pc_to_reg;
        logic halt;
    } wb_ctrl_t;

    // Halt sequencing: DRAIN once a halting ECALL has entered the pipe,
    // HALTED once it has retired. Bit 1 of the encoding is the halted flag.
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } halt_state_t;

    // Opcode decode; unknown opcodes yield an all-zero, invalid bundle.
    function automatic ex_ctrl_t decode_op(input logic [6:0] op, input logic hc);
        ex_ctrl_t c;
        c = '0;
        case (op)
            OP_ARITH: begin
                c.valid = 1'b1; c.write_enable = 1'b1;
            end
            OP_ARITH_IMM, OP_LUI, OP_AUIPC: begin
                c.valid = 1'b1; c.alu_src = 1'b1; c.write_enable = 1'b1;
            end
            OP_LOAD: begin
                c.valid = 1'b1; c.alu_src = 1'b1; c.write_enable = 1'b1;
                c.mem_read = 1'b1; c.mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                c.valid = 1'b1; c.alu_src = 1'b1; c.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                c.valid = 1'b1; c.branch = 1'b1;
            end
            OP_JAL: begin
                c.valid = 1'b1; c.alu_src = 1'b1; c.write_enable = 1'b1;
                c.pc_to_reg = 1'b1; c.is_jal = 1'b1;
            end
            OP_JALR: begin
                c.valid = 1'b1; c.alu_src = 1'b1; c.write_enable = 1'b1;
                c.pc_to_reg = 1'b1; c.is_jalr = 1'b1;
            end
            OP_SYSTEM: begin
                c.valid = 1'b1; c.halt = hc;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    ex_ctrl_t    dec_s;
    ex_ctrl_t    ex_d, ex_q;
    mem_ctrl_t   mem_in_s;
    mem_ctrl_t   mem_q [MEM_STAGES];
    wb_ctrl_t    wb_d, wb_q;
    halt_state_t state_d, state_q;
    logic        id_load_s;

    // ID decode and ID/EX next value: bubble unless a valid, unstalled,
    // unflushed instruction arrives while the core is still running.
    always_comb begin
        dec_s     = decode_op(bus.opcode, bus.halt_cond);
        id_load_s = bus.in_valid & ~bus.stall & ~bus.flush & (state_q == ST_RUN);
        if (id_load_s) begin
            ex_d = dec_s;
        end else begin
            ex_d = '0;
        end
    end

    // Narrow the bundle at the EX->MEM and MEM->WB boundaries.
    always_comb begin
        mem_in_s.valid        = ex_q.valid;
        mem_in_s.mem_read     = ex_q.mem_read;
        mem_in_s.mem_write    = ex_q.mem_write;
        mem_in_s.write_enable = ex_q.write_enable;
        mem_in_s.mem_to_reg   = ex_q.mem_to_reg;
        mem_in_s.pc_to_reg    = ex_q.pc_to_reg;
        mem_in_s.halt         = ex_q.halt;
        wb_d.valid            = mem_q[MEM_STAGES-1].valid;
        wb_d.write_enable     = mem_q[MEM_STAGES-1].write_enable;
        wb_d.mem_to_reg       = mem_q[MEM_STAGES-1].mem_to_reg;
        wb_d.pc_to_reg        = mem_q[MEM_STAGES-1].pc_to_reg;
        wb_d.halt             = mem_q[MEM_STAGES-1].halt;
    end

    // Pipeline registers; downstream of ID/EX everything always advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q <= '0;
            for (int i = 0; i < MEM_STAGES; i++) begin
                mem_q[i] <= '0;
            end
            wb_q <= '0;
        end else begin
            ex_q     <= ex_d;
            mem_q[0] <= mem_in_s;
            for (int i = 1; i < MEM_STAGES; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
            wb_q <= wb_d;
        end
    end

    // Halt FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (ex_d.valid && ex_d.halt) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (wb_q.valid && wb_q.halt) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_HALTED;
        endcase
    end

    // Halt FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef RETIRE_COUNT_EN
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Count bundles retiring in WB until the core is halted; wraps naturally.
    always_comb begin
        if (wb_q.valid && (state_q != ST_HALTED)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Retire counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.retire_count = cnt_q;
`else
    assign bus.retire_count = {CNT_W{1'b0}};
`endif

    assign bus.ex_valid        = ex_q.valid;
    assign bus.ex_alu_src      = ex_q.alu_src;
    assign bus.ex_branch       = ex_q.branch;
    assign bus.ex_is_jal       = ex_q.is_jal;
    assign bus.ex_is_jalr      = ex_q.is_jalr;
    assign bus.mem_read        = mem_q[MEM_STAGES-1].mem_read;
    assign bus.mem_write       = mem_q[MEM_STAGES-1].mem_write;
    assign bus.wb_write_enable = wb_q.write_enable;
    assign bus.wb_mem_to_reg   = wb_q.mem_to_reg;
    assign bus.wb_pc_to_reg    = wb_q.pc_to_reg;
    assign bus.is_halted       = state_q[1];
    // Combinational by design: flags the opcode currently in ID.
    assign bus.illegal_inst    = bus.in_valid & ~dec_s.valid;
endmodule
